// File: rtl/i2c_regs_pkg.sv
// rtl/i2c_regs_pkg.sv - shared types and constants for the I2C register controller
package i2c_regs_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [1:0]        state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_GET_PTR    = 2'd1;
    localparam state_t ST_WRITE_DATA = 2'd2;

endpackage

// File: rtl/i2c_reg_readmux.sv
// rtl/i2c_reg_readmux.sv - combinational address-to-value mux over RW, RO and unmapped space
module i2c_reg_readmux
    import i2c_regs_pkg::*;
#(
    parameter int    NUM_RW       = 4,
    parameter int    NUM_RO       = 2,
    parameter byte_t UNMAPPED_VAL = 8'hFF
) (
    input  logic [BYTE_W-1:0]        addr,
    input  logic [BYTE_W*NUM_RW-1:0] rw_flat,
    input  logic [BYTE_W*NUM_RO-1:0] ro_flat,
    output logic [BYTE_W-1:0]        value
);

    // Decoded by equality so any 8-bit address is safe against the parameterised ranges.
    always_comb begin
        value = UNMAPPED_VAL;
        for (int k = 0; k < NUM_RW; k++) begin
            if (addr == byte_t'(k)) begin
                value = rw_flat[k*BYTE_W +: BYTE_W];
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (addr == byte_t'(NUM_RW + k)) begin
                value = ro_flat[k*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/i2c_register_controller.sv
// rtl/i2c_register_controller.sv - pointer/auto-increment register file behind an I2C slave byte stream
module i2c_register_controller
    import i2c_regs_pkg::*;
#(
    parameter int    NUM_RW       = 4,
    parameter int    NUM_RO       = 2,
    parameter byte_t RW_RESET     = 8'h00,
    parameter byte_t UNMAPPED_VAL = 8'hFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i2c_start_stb,
    input  logic                      i2c_stop_stb,
    input  logic [BYTE_W-1:0]         i2c_rx,
    input  logic                      i2c_rx_valid,
    input  logic                      i2c_tx_done_stb,
    output logic [BYTE_W-1:0]         i2c_tx,
    input  logic [BYTE_W*NUM_RO-1:0]  ro_in,
    output logic [BYTE_W*NUM_RW-1:0]  rw_out,
    output logic                      wr_stb,
    output logic [BYTE_W-1:0]         wr_addr,
    output logic                      busy
);

    localparam byte_t TX_RESET = (NUM_RW == 0) ? UNMAPPED_VAL : RW_RESET;

    state_t state;
    state_t next_state;
    byte_t  ptr;
    byte_t  rw_q [NUM_RW];
    byte_t  rd_value;
    logic   rx_accept;
    logic   ptr_load;
    logic   ptr_inc;
    logic   wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // STOP beats START beats data; a dropped data strobe never changes state.
    always_comb begin
        next_state = state;
        if (i2c_stop_stb) begin
            next_state = ST_IDLE;
        end else if (i2c_start_stb) begin
            next_state = ST_GET_PTR;
        end else if (state == ST_GET_PTR && i2c_rx_valid) begin
            next_state = ST_WRITE_DATA;
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        rx_accept = busy && i2c_rx_valid && !i2c_stop_stb && !i2c_start_stb;
        ptr_load  = rx_accept && (state == ST_GET_PTR);
        // rx_valid wins over a coincident tx_done so the pointer moves only once.
        ptr_inc   = (rx_accept && (state == ST_WRITE_DATA))
                 || (busy && i2c_tx_done_stb && !i2c_rx_valid
                     && !i2c_stop_stb && !i2c_start_stb);
        wr_en     = rx_accept && (state == ST_WRITE_DATA) && (int'(ptr) < NUM_RW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            i2c_tx  <= TX_RESET;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                rw_q[k] <= RW_RESET;
            end
        end else begin
            if (ptr_load) begin
                ptr <= i2c_rx;
            end else if (ptr_inc) begin
                ptr <= ptr + byte_t'(1);
            end
            for (int k = 0; k < NUM_RW; k++) begin
                if (wr_en && ptr == byte_t'(k)) begin
                    rw_q[k] <= i2c_rx;
                end
            end
            wr_stb <= wr_en;
            if (wr_en) begin
                wr_addr <= ptr;
            end
            i2c_tx <= rd_value;
        end
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw_out
        assign rw_out[k*BYTE_W +: BYTE_W] = rw_q[k];
    end

    i2c_reg_readmux #(
        .NUM_RW       (NUM_RW),
        .NUM_RO       (NUM_RO),
        .UNMAPPED_VAL (UNMAPPED_VAL)
    ) u_readmux (
        .addr    (ptr),
        .rw_flat (rw_out),
        .ro_flat (ro_in),
        .value   (rd_value)
    );

endmodule

// File: doc/i2c_register_controller.md
Name: i2c_register_controller

Overview:
- Register-file controller sequencing the byte stream of the i2c_simple_slave.
- Interprets the first received byte of each transaction as a register pointer. Subsequent received bytes are writes with pointer auto-increment.
- Feeds the slave's transmit byte from the register at the pointer, and advances the pointer each time a byte is sent.
- Sits between the slave and application logic (RGB drive, button status) in the top level.

Parameters:
- NUM_RW, 4, number of read/write registers at addresses 0..NUM_RW-1 (1..128).
- NUM_RO, 2, number of read-only registers at addresses NUM_RW..NUM_RW+NUM_RO-1 (0..128; NUM_RW+NUM_RO <= 256).
- RW_RESET, 8'h00, reset value of every RW register.
- UNMAPPED_VAL, 8'hFF, value returned when reading an unmapped address.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- i2c_start_stb  in  1  one-cycle pulse on START or repeated START addressed to this slave.
- i2c_stop_stb  in  1  one-cycle pulse on STOP.
- i2c_rx  in  8  received data byte (i2c_data_rx).
- i2c_rx_valid  in  1  one-cycle strobe; i2c_rx valid (i2c_data_rx_valid_stb).
- i2c_tx_done_stb  in  1  one-cycle pulse when the slave has latched i2c_tx for transmission.
- i2c_tx  out  8  next byte to transmit (i2c_data_tx).
- ro_in  in  8*NUM_RO  read-only register values; byte k maps to address NUM_RW+k; sampled live.
- rw_out  out  8*NUM_RW  RW register contents; byte k is register k.
- wr_stb  out  1  one-cycle pulse when an RW register is written.
- wr_addr  out  8  address written; valid with wr_stb.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state=IDLE, ptr=8'h00, all RW registers=RW_RESET;
  - i2c_tx=RW_RESET, or UNMAPPED_VAL if NUM_RW=0; wr_stb=0, wr_addr=0, busy=0.
- Reset overrides all inputs on the same cycle and aborts any transaction; no write occurs that cycle.
- States:
  - IDLE: rx bytes are ignored. start -> GET_PTR.
  - GET_PTR: rx_valid -> ptr<=i2c_rx, then -> WRITE_DATA. stop -> IDLE. start -> GET_PTR.
  - WRITE_DATA: rx_valid -> write i2c_rx to address ptr, then ptr<=ptr+1. stop -> IDLE. start -> GET_PTR.
- Priority within one cycle is rst > stop > start > rx_valid/tx_done. A lower-priority strobe coinciding with a higher one is dropped.
- Write rules:
  - ptr<NUM_RW: the register updates at the next edge. wr_stb=1 and wr_addr=ptr (pre-increment value) on the cycle the new value appears.
  - ptr>=NUM_RW: the write is discarded and wr_stb stays 0. The pointer still increments.
- Pointer is 8 bits and wraps 8'hFF -> 8'h00 on both writes and reads.
- Pointer is retained across STOP/START, so write-pointer-then-repeated-START-then-read works.
- Read path:
  - i2c_tx is registered: i2c_tx <= value(ptr) every cycle, i.e. one cycle of latency after any change to ptr, register contents or ro_in.
  - value(a) = RW[a] for a<NUM_RW; ro_in byte (a-NUM_RW) for NUM_RW<=a<NUM_RW+NUM_RO; UNMAPPED_VAL otherwise.
  - tx_done_stb -> ptr<=ptr+1 in any state except IDLE. In IDLE it is ignored.
  - Slave guarantees >=2 clk cycles between tx_done_stb and the next byte latch, so the new i2c_tx is always ready.
- rx_valid and tx_done_stb never coincide (protocol direction exclusive). If they do, rx_valid wins and the pointer increments once.
- busy is a combinational decode of state (IDLE -> 0).

Decomposition:
- Shared package i2c_regs_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GET_PTR=2'd1, ST_WRITE_DATA=2'd2;
  - the I2C byte width constant (8).
- One sub-module is natural: i2c_reg_readmux, a combinational address-to-value mux over RW/RO/unmapped. Registering of i2c_tx stays in the parent.

Test Plan:
- Write burst: start, rx 8'h01, rx 8'hAA, rx 8'h55, stop -> RW1=AA, RW2=55; wr_stb pulses with wr_addr 1 then 2; ptr=3; busy returns 0.
- Pointer-then-read: start, rx 8'h04, repeated start, tx_done x2, stop with ro_in={8'hB2,8'hB1} -> i2c_tx shows B1, then B2 one cycle after the first tx_done, then FF (ptr=6, unmapped).
- Unmapped/wrap: start, rx 8'hFF, rx 8'h12, rx 8'h34 -> no write at FF; RW0=8'h34; wr_addr=0; ptr=1.
- Idle ignore: rx_valid 8'h77 with no preceding start -> no register change, ptr unchanged, wr_stb 0.
- Simultaneous: stop and rx_valid same cycle during WRITE_DATA -> byte dropped, state IDLE; start and rx_valid same cycle -> state GET_PTR, byte dropped.
- Reset mid-write: rst asserted on the same cycle as rx_valid in WRITE_DATA -> no write; all RW=RW_RESET, ptr=0, state IDLE next cycle.
